// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: signal bundle between the interrupt front end and its
// neighbours (board-level interrupt sources plus the mips core).
// master = sources/core side, slave = irq_ctrl side.
interface irq_ctrl_if #(
  parameter int N_IRQ = 4
) ();
  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             irq_ack;
  logic             irq_eret;
  logic             interrupter;
  logic [CW-1:0]    irq_cause;
  logic [N_IRQ-1:0] irq_pending;
  logic             irq_busy;

  modport master (
    output irq_in, irq_mask, irq_ack, irq_eret,
    input  interrupter, irq_cause, irq_pending, irq_busy
  );

  modport slave (
    input  irq_in, irq_mask, irq_ack, irq_eret,
    output interrupter, irq_cause, irq_pending, irq_busy
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: external-interrupt front end for the mips core.
// Synchronizes N_IRQ raw lines, latches rising edges as pending requests,
// masks them, and hands the lowest-index enabled request to the core via
// an interrupter/ack/eret handshake (no nesting).
// Optional feature: define IRQ_DEBOUNCE_EN to add a per-line stable-count
// filter of DEBOUNCE_CYCLES cycles between synchronizer and edge detector.
module irq_ctrl #(
  parameter int N_IRQ           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  irq_ctrl_if.slave  bus
);
  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  if (N_IRQ < 1 || N_IRQ > 16 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("irq_ctrl: need 1<=N_IRQ<=16, SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] sync_out;
  logic [N_IRQ-1:0] lvl;
  logic [N_IRQ-1:0] lvl_prev_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pend_q, pend_d, pend_clr;
  logic [N_IRQ-1:0] req;
  state_e           state_q, state_d;
  logic             interrupter_q, interrupter_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic             busy_q, busy_d;

  // Lowest set index of a request vector (0 when empty).
  function automatic logic [CW-1:0] first_set(input logic [N_IRQ-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  // Multi-flop synchronizer shifting each raw line into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_IRQ-1:0]          lvl_q, lvl_d;
  logic [N_IRQ-1:0][DBW-1:0] db_cnt_q, db_cnt_d;

  // Level follows the synchronized input only after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (sync_out[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = sync_out[i];
        else                                          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounced level and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_out;
`endif

  // Delayed copy of the level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_prev_q <= '0;
    else     lvl_prev_q <= lvl;
  end

  assign rise   = lvl & ~lvl_prev_q;
  // A fresh edge on a line being cleared in the same cycle keeps it pending.
  assign pend_d = (pend_q & ~pend_clr) | rise;
  assign req    = pend_q & bus.irq_mask;

  // Pending vector, independent of the mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Handshake FSM: next state and registered outputs.
  always_comb begin
    state_d       = state_q;
    interrupter_d = interrupter_q;
    cause_d       = cause_q;
    busy_d        = busy_q;
    pend_clr      = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          cause_d       = first_set(req);
          interrupter_d = 1'b1;
          state_d       = REQ;
        end
      end
      REQ: begin
        // The core taking the exception wins over a same-cycle mask drop.
        if (bus.irq_ack) begin
          pend_clr[cause_q] = 1'b1;
          interrupter_d     = 1'b0;
          busy_d            = 1'b1;
          state_d           = SERVICE;
        end else if (!bus.irq_mask[cause_q]) begin
          interrupter_d = 1'b0;
          state_d       = IDLE;
        end
      end
      SERVICE: begin
        if (bus.irq_eret) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        interrupter_d = 1'b0;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      interrupter_q <= 1'b0;
      cause_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      interrupter_q <= interrupter_d;
      cause_q       <= cause_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.interrupter = interrupter_q;
  assign bus.irq_cause   = cause_q;
  assign bus.irq_pending = pend_q;
  assign bus.irq_busy    = busy_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven bench for irq_ctrl with an expected-value queue,
// plus hand-written sequences for async reset and (when IRQ_DEBOUNCE_EN is
// defined) the debounce filter.
module tb_irq_ctrl;
  localparam int N = 4;
`ifdef IRQ_DEBOUNCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_ctrl_if #(.N_IRQ(N)) bus ();

  irq_ctrl #(
    .N_IRQ(N),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       all;
    logic       intr;
    logic [1:0] cause;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  typedef struct packed {
    logic [3:0] in;
    logic [3:0] mask;
    logic       ack;
    logic       eret;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_err    = 0;
  int   n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic [3:0] in, input logic [3:0] mask,
                              input logic ack, input logic eret, input logic e_int,
                              input logic [1:0] e_cause, input logic [3:0] e_pend,
                              input logic e_busy);
    vec_t v;
    v.in = in; v.mask = mask; v.ack = ack; v.eret = eret;
    v.e.all = 1'b1; v.e.intr = e_int; v.e.cause = e_cause;
    v.e.pend = e_pend; v.e.busy = e_busy;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  // Drive one vector on the falling edge, queue its expectation, and score it
  // just after the rising edge that samples it.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    bus.irq_in   = v.in;
    bus.irq_mask = v.mask;
    bus.irq_ack  = v.ack;
    bus.irq_eret = v.eret;
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".pend"}, 32'(bus.irq_pending), 32'(e.pend));
    if (e.all) begin
      check({tag, ".int"},   32'(bus.interrupter), 32'(e.intr));
      check({tag, ".cause"}, 32'(bus.irq_cause),   32'(e.cause));
      check({tag, ".busy"},  32'(bus.irq_busy),    32'(e.busy));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n_req;
    int   first_c;
    vec_t v;

    bus.irq_in   = '0;
    bus.irq_mask = '0;
    bus.irq_ack  = 1'b0;
    bus.irq_eret = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.int",   32'(bus.interrupter), 32'd0);
    check("rst.cause", 32'(bus.irq_cause),   32'd0);
    check("rst.pend",  32'(bus.irq_pending), 32'd0);
    check("rst.busy",  32'(bus.irq_busy),    32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifndef IRQ_DEBOUNCE_EN
    //  n  in       mask     ack eret  int cause pend     busy
    // single request on line 0; ack in SERVICE is ignored
    add(2, 4'b0001, 4'b0001, 0, 0,     0,  0,    4'b0000, 0);
    add(1, 4'b0001, 4'b0001, 0, 0,     0,  0,    4'b0001, 0);
    add(1, 4'b0001, 4'b0001, 0, 0,     1,  0,    4'b0001, 0);
    add(1, 4'b0001, 4'b0001, 1, 0,     0,  0,    4'b0000, 1);
    add(1, 4'b0001, 4'b0001, 1, 0,     0,  0,    4'b0000, 1);
    add(1, 4'b0001, 4'b0001, 0, 1,     0,  0,    4'b0000, 0);
    add(3, 4'b0001, 4'b0001, 0, 0,     0,  0,    4'b0000, 0);
    add(3, 4'b0000, 4'b0001, 0, 0,     0,  0,    4'b0000, 0);
    // priority: lines 3 and 1 together
    add(2, 4'b1010, 4'b1111, 0, 0,     0,  0,    4'b0000, 0);
    add(1, 4'b1010, 4'b1111, 0, 0,     0,  0,    4'b1010, 0);
    add(1, 4'b1010, 4'b1111, 0, 0,     1,  1,    4'b1010, 0);
    add(1, 4'b1010, 4'b1111, 1, 0,     0,  1,    4'b1000, 1);
    add(1, 4'b1010, 4'b1111, 0, 1,     0,  1,    4'b1000, 0);
    add(1, 4'b1010, 4'b1111, 0, 0,     1,  3,    4'b1000, 0);
    add(1, 4'b1010, 4'b1111, 1, 0,     0,  3,    4'b0000, 1);
    add(1, 4'b1010, 4'b1111, 0, 1,     0,  3,    4'b0000, 0);
    add(1, 4'b1010, 4'b1111, 0, 0,     0,  3,    4'b0000, 0);
    // masked line 2 latches pending, serviced once unmasked
    add(2, 4'b0100, 4'b0000, 0, 0,     0,  3,    4'b0000, 0);
    add(2, 4'b0100, 4'b0000, 0, 0,     0,  3,    4'b0100, 0);
    add(1, 4'b0100, 4'b0100, 0, 0,     1,  2,    4'b0100, 0);
    add(1, 4'b0100, 4'b0100, 1, 0,     0,  2,    4'b0000, 1);
    add(1, 4'b0100, 4'b0100, 0, 1,     0,  2,    4'b0000, 0);
    // withdraw by mask drop while in REQ
    add(2, 4'b0001, 4'b0001, 0, 0,     0,  2,    4'b0000, 0);
    add(1, 4'b0001, 4'b0001, 0, 0,     0,  2,    4'b0001, 0);
    add(1, 4'b0001, 4'b0001, 0, 0,     1,  0,    4'b0001, 0);
    add(2, 4'b0001, 4'b0000, 0, 0,     0,  0,    4'b0001, 0);
    add(1, 4'b0001, 4'b0001, 0, 0,     1,  0,    4'b0001, 0);
    add(1, 4'b0001, 4'b0001, 1, 0,     0,  0,    4'b0000, 1);
    add(1, 4'b0001, 4'b0001, 0, 1,     0,  0,    4'b0000, 0);
    // ack and eret in IDLE are ignored
    add(1, 4'b0001, 4'b0001, 1, 1,     0,  0,    4'b0000, 0);
    add(3, 4'b0000, 4'b0000, 0, 0,     0,  0,    4'b0000, 0);
    // collision: new edge on line 1 in the ack cycle; eret in REQ ignored
    add(2, 4'b0010, 4'b0010, 0, 0,     0,  0,    4'b0000, 0);
    add(1, 4'b0010, 4'b0010, 0, 0,     0,  0,    4'b0010, 0);
    add(1, 4'b0000, 4'b0010, 0, 0,     1,  1,    4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 0, 1,     1,  1,    4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 0, 0,     1,  1,    4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 1, 0,     0,  1,    4'b0010, 1);
    add(1, 4'b0010, 4'b0010, 0, 0,     0,  1,    4'b0010, 1);
    add(1, 4'b0010, 4'b0010, 0, 1,     0,  1,    4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 0, 0,     1,  1,    4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 1, 0,     0,  1,    4'b0000, 1);
    add(1, 4'b0010, 4'b0010, 0, 1,     0,  1,    4'b0000, 0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
`endif

    // Async reset while in REQ, then a line held high across release
    @(negedge clk);
    bus.irq_in   = 4'b0001;
    bus.irq_mask = 4'b0001;
    bus.irq_ack  = 1'b0;
    bus.irq_eret = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.interrupter) seen = 1'b1;
    end
    check("arst.req_seen", 32'(seen), 32'd1);
    if (seen) begin
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst.int",   32'(bus.interrupter), 32'd0);
      check("arst.cause", 32'(bus.irq_cause),   32'd0);
      check("arst.pend",  32'(bus.irq_pending), 32'd0);
      check("arst.busy",  32'(bus.irq_busy),    32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_req   = 0;
      first_c = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.interrupter) begin
          n_req++;
          if (first_c < 0) begin
            first_c = c;
            check("post_rst.cause", 32'(bus.irq_cause), 32'd0);
          end
        end
        bus.irq_ack  = bus.interrupter;
        bus.irq_eret = bus.irq_busy;
      end
      bus.irq_ack  = 1'b0;
      bus.irq_eret = 1'b0;
      check("post_rst.n_req",   32'(n_req),   32'd1);
      check("post_rst.latency", 32'(first_c), 32'(3 + EXTRA));
    end

`ifdef IRQ_DEBOUNCE_EN
    // Debounce: settle low, 3-cycle glitch rejected, 6-cycle pulse accepted
    v = '0;
    v.e.all = 1'b0;
    for (int k = 0; k < 12; k++) apply(v, $sformatf("db_low%0d", k));
    v.in = 4'b0001;
    for (int k = 0; k < 3; k++) apply(v, $sformatf("db_glitch%0d", k));
    v.in = 4'b0000;
    for (int k = 0; k < 10; k++) apply(v, $sformatf("db_after%0d", k));
    for (int k = 0; k < 10; k++) begin
      v.in     = (k < 6) ? 4'b0001 : 4'b0000;
      v.e.pend = (k >= 2 + 4) ? 4'b0001 : 4'b0000;
      apply(v, $sformatf("db_pulse%0d", k));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
